// File: rtl/gradient_kernel_pipeline.sv
// Generalised Sobel gradient stage: one KxK window per transfer in, signed Gx/Gy,
// saturated magnitude and edge flag out through a four-stage valid/ready pipeline.
module gradient_kernel_pipeline #(
   parameter  int DATA_WIDTH  = 8,
   parameter  int KERNEL_SIZE = 5,
   parameter  int MAG_WIDTH   = 16,
   localparam int C           = (KERNEL_SIZE - 1) / 2,
   localparam int SUMW        = (C * (C + 1) * (C + 1) * (C + 1)) / 2,
   localparam int GW          = DATA_WIDTH + $clog2(SUMW + 1) + 1
) (
   input  logic                  clk,
   input  logic                  aresetn,
   input  logic [DATA_WIDTH-1:0] i_window [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1],
   input  logic                  i_valid,
   input  logic                  i_sof,
   input  logic                  i_eol,
   output logic                  o_ready,
   input  logic                  i_mode,
   input  logic [MAG_WIDTH-1:0]  i_threshold,
   output logic signed [GW-1:0]  o_gx,
   output logic signed [GW-1:0]  o_gy,
   output logic [MAG_WIDTH-1:0]  o_mag,
   output logic                  o_edge,
   output logic                  o_valid,
   output logic                  o_sof,
   output logic                  o_eol,
   input  logic                  i_out_ready
);

   // Magnitude is formed one bit wider than a gradient so the L1 sum cannot wrap.
   localparam int SW = ((GW + 1) > MAG_WIDTH) ? (GW + 1) : MAG_WIDTH;
   localparam logic [SW-1:0] MAG_MAX = SW'({MAG_WIDTH{1'b1}});

   if ((KERNEL_SIZE < 3) || (KERNEL_SIZE > 7) || ((KERNEL_SIZE % 2) == 0)) begin : g_bad_kernel
      $error("gradient_kernel_pipeline: KERNEL_SIZE must be odd and within 3..7");
   end

   logic                 en;
   logic                 v1, v2, v3;
   logic                 sof1, sof2, sof3;
   logic                 eol1, eol2, eol3;
   logic signed [GW-1:0] row_gx_d [KERNEL_SIZE];
   logic signed [GW-1:0] col_gy_d [KERNEL_SIZE];
   logic signed [GW-1:0] row_gx_q [KERNEL_SIZE];
   logic signed [GW-1:0] col_gy_q [KERNEL_SIZE];
   logic signed [GW-1:0] gx_d, gy_d, gx2, gy2, gx3, gy3;
   logic [GW-1:0]        ax_d, ay_d, ax3, ay3;
   logic [SW-1:0]        mag_d;
   logic                 edge_d;

   assign en      = ~o_valid | i_out_ready;
   assign o_ready = en;

   // S1: horizontal taps weighted by column offset per row, vertical taps by row offset per column.
   always_comb begin
      logic signed [GW-1:0] pix;
      logic signed [GW-1:0] acc;
      pix = '0;
      acc = '0;
      for (int r = 0; r < KERNEL_SIZE; r++) begin
         acc = '0;
         for (int c = 0; c < KERNEL_SIZE; c++) begin
            pix = $signed({{(GW-DATA_WIDTH){1'b0}}, i_window[r][c]});
            acc = acc + (GW'(c - C) * pix);
         end
         row_gx_d[r] = acc;
      end
      for (int c = 0; c < KERNEL_SIZE; c++) begin
         acc = '0;
         for (int r = 0; r < KERNEL_SIZE; r++) begin
            pix = $signed({{(GW-DATA_WIDTH){1'b0}}, i_window[r][c]});
            acc = acc + (GW'(r - C) * pix);
         end
         col_gy_d[c] = acc;
      end
   end

   // S2: apply the triangular smoothing weight C+1-|i-C| across rows (Gx) and columns (Gy).
   always_comb begin
      logic signed [GW-1:0] wgt;
      logic signed [GW-1:0] acc_x;
      logic signed [GW-1:0] acc_y;
      wgt   = '0;
      acc_x = '0;
      acc_y = '0;
      for (int i = 0; i < KERNEL_SIZE; i++) begin
         wgt   = GW'(C + 1 - ((i >= C) ? (i - C) : (C - i)));
         acc_x = acc_x + (wgt * row_gx_q[i]);
         acc_y = acc_y + (wgt * col_gy_q[i]);
      end
      gx_d = acc_x;
      gy_d = acc_y;
   end

   // S3: absolute values; the most negative code is unreachable so negation is safe.
   always_comb begin
      ax_d = gx2[GW-1] ? $unsigned(-gx2) : $unsigned(gx2);
      ay_d = gy2[GW-1] ? $unsigned(-gy2) : $unsigned(gy2);
   end

   // S4: magnitude per mode, saturated, plus the threshold compare for valid windows only.
   always_comb begin
      logic [SW-1:0] ax_w, ay_w, mx, mn, raw;
      ax_w   = SW'(ax3);
      ay_w   = SW'(ay3);
      mx     = (ax_w >= ay_w) ? ax_w : ay_w;
      mn     = (ax_w >= ay_w) ? ay_w : ax_w;
      raw    = '0;
      mag_d  = '0;
      edge_d = 1'b0;
      case (i_mode)
         1'b0:    raw = ax_w + ay_w;
         1'b1:    raw = mx + {1'b0, mn[SW-1:1]};
         default: raw = ax_w + ay_w;
      endcase
      if (raw > MAG_MAX) begin
         mag_d = MAG_MAX;
      end else begin
         mag_d = raw;
      end
      edge_d = v3 & (mag_d[MAG_WIDTH-1:0] >= i_threshold);
   end

   // Valid and sideband bits move with the global enable; bubbles carry sof=eol=0.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         v1      <= 1'b0;
         v2      <= 1'b0;
         v3      <= 1'b0;
         o_valid <= 1'b0;
         sof1    <= 1'b0;
         sof2    <= 1'b0;
         sof3    <= 1'b0;
         o_sof   <= 1'b0;
         eol1    <= 1'b0;
         eol2    <= 1'b0;
         eol3    <= 1'b0;
         o_eol   <= 1'b0;
      end else if (en) begin
         v1      <= i_valid;
         v2      <= v1;
         v3      <= v2;
         o_valid <= v3;
         sof1    <= i_sof & i_valid;
         sof2    <= sof1;
         sof3    <= sof2;
         o_sof   <= sof3;
         eol1    <= i_eol & i_valid;
         eol2    <= eol1;
         eol3    <= eol2;
         o_eol   <= eol3;
      end
   end

   // Datapath registers share the same enable so a stall freezes every stage together.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         row_gx_q <= '{default: '0};
         col_gy_q <= '{default: '0};
         gx2      <= '0;
         gy2      <= '0;
         gx3      <= '0;
         gy3      <= '0;
         ax3      <= '0;
         ay3      <= '0;
         o_gx     <= '0;
         o_gy     <= '0;
         o_mag    <= '0;
         o_edge   <= 1'b0;
      end else if (en) begin
         row_gx_q <= row_gx_d;
         col_gy_q <= col_gy_d;
         gx2      <= gx_d;
         gy2      <= gy_d;
         gx3      <= gx2;
         gy3      <= gy2;
         ax3      <= ax_d;
         ay3      <= ay_d;
         o_gx     <= gx3;
         o_gy     <= gy3;
         o_mag    <= mag_d[MAG_WIDTH-1:0];
         o_edge   <= edge_d;
      end
   end

endmodule

// File: tb/tb_gradient_kernel_pipeline.sv
// Bench for gradient_kernel_pipeline: a K=5/16-bit and a K=3/8-bit instance share one
// handshake; outputs are scored against a direct kernel-sum reference model.
module tb_gradient_kernel_pipeline;

   localparam int DW  = 8;
   localparam int KA  = 5;
   localparam int MWA = 16;
   localparam int CA  = 2;
   localparam int GWA = DW + $clog2((CA * (CA + 1) * (CA + 1) * (CA + 1)) / 2 + 1) + 1;
   localparam int KB  = 3;
   localparam int MWB = 8;
   localparam int CB  = 1;
   localparam int GWB = DW + $clog2((CB * (CB + 1) * (CB + 1) * (CB + 1)) / 2 + 1) + 1;

   typedef struct {
      int gx;
      int gy;
      int mag;
      bit edg;
      bit sof;
      bit eol;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            aresetn;
   logic            in_valid, in_sof, in_eol, mode, out_ready;
   logic [MWA-1:0]  thr_a;
   logic [MWB-1:0]  thr_b;
   logic [DW-1:0]   win_a [0:KA-1][0:KA-1];
   logic [DW-1:0]   win_b [0:KB-1][0:KB-1];

   logic                   ready_a, edge_a, valid_a, sof_a, eol_a;
   logic signed [GWA-1:0]  gx_a, gy_a;
   logic [MWA-1:0]         mag_a;
   logic                   ready_b, edge_b, valid_b, sof_b, eol_b;
   logic signed [GWB-1:0]  gx_b, gy_b;
   logic [MWB-1:0]         mag_b;

   gradient_kernel_pipeline #(.DATA_WIDTH(DW), .KERNEL_SIZE(KA), .MAG_WIDTH(MWA)) dut_a (
      .clk(clk), .aresetn(aresetn), .i_window(win_a), .i_valid(in_valid), .i_sof(in_sof),
      .i_eol(in_eol), .o_ready(ready_a), .i_mode(mode), .i_threshold(thr_a), .o_gx(gx_a),
      .o_gy(gy_a), .o_mag(mag_a), .o_edge(edge_a), .o_valid(valid_a), .o_sof(sof_a),
      .o_eol(eol_a), .i_out_ready(out_ready)
   );

   gradient_kernel_pipeline #(.DATA_WIDTH(DW), .KERNEL_SIZE(KB), .MAG_WIDTH(MWB)) dut_b (
      .clk(clk), .aresetn(aresetn), .i_window(win_b), .i_valid(in_valid), .i_sof(in_sof),
      .i_eol(in_eol), .o_ready(ready_b), .i_mode(mode), .i_threshold(thr_b), .o_gx(gx_b),
      .o_gy(gy_b), .o_mag(mag_b), .o_edge(edge_b), .o_valid(valid_b), .o_sof(sof_b),
      .o_eol(eol_b), .i_out_ready(out_ready)
   );

   exp_t qa[$];
   exp_t qb[$];
   int   pa [7][7];
   int   pb [7][7];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   rdy_mode = 0;

   task automatic check_eq(input string tag, input longint obs, input longint want);
      n_checks++;
      if (obs == want) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, want, $time);
   endtask

   function automatic int iabs(input int x);
      return (x < 0) ? -x : x;
   endfunction

   // Reference: coefficients straight from the generalised Sobel formula over the whole window.
   function automatic exp_t model(input int k, input int mw, input int p[7][7], input bit md,
                                  input int thr, input bit s, input bit e);
      exp_t t;
      int cc, ax, ay, hi, lo, m, lim;
      cc   = (k - 1) / 2;
      t.gx = 0;
      t.gy = 0;
      for (int r = 0; r < k; r++) begin
         for (int c = 0; c < k; c++) begin
            t.gx += (c - cc) * (cc + 1 - iabs(r - cc)) * p[r][c];
            t.gy += (r - cc) * (cc + 1 - iabs(c - cc)) * p[r][c];
         end
      end
      ax  = iabs(t.gx);
      ay  = iabs(t.gy);
      hi  = (ax > ay) ? ax : ay;
      lo  = (ax > ay) ? ay : ax;
      m   = md ? (hi + lo / 2) : (ax + ay);
      lim = (1 << mw) - 1;
      if (m > lim) m = lim;
      t.mag = m;
      t.edg = (m >= thr);
      t.sof = s;
      t.eol = e;
      return t;
   endfunction

   // Patterns: 0 ramp, 1 all 255, 2 left 0 / right 255, 3 uniform random, 4 random 0/255.
   task automatic fill(input int pat);
      for (int r = 0; r < 7; r++) begin
         for (int c = 0; c < 7; c++) begin
            case (pat)
               0: begin pa[r][c] = 25 - 5 * r - c; pb[r][c] = 9 - 3 * r - c; end
               1: begin pa[r][c] = 255; pb[r][c] = 255; end
               2: begin pa[r][c] = (c > CA) ? 255 : 0; pb[r][c] = (c > CB) ? 255 : 0; end
               3: begin pa[r][c] = int'($urandom_range(0, 255)); pb[r][c] = int'($urandom_range(0, 255)); end
               default: begin
                  pa[r][c] = ($urandom_range(0, 1) == 1) ? 255 : 0;
                  pb[r][c] = ($urandom_range(0, 1) == 1) ? 255 : 0;
               end
            endcase
         end
      end
      for (int r = 0; r < KA; r++)
         for (int c = 0; c < KA; c++) win_a[r][c] = pa[r][c][7:0];
      for (int r = 0; r < KB; r++)
         for (int c = 0; c < KB; c++) win_b[r][c] = pb[r][c][7:0];
   endtask

   // Output scoring against the queue head (held values are re-checked every stalled cycle),
   // then enqueue whatever the upcoming edge accepts.
   always @(negedge clk) begin
      if (aresetn) begin
         if (valid_a) begin
            if (qa.size() == 0) check_eq("a_spurious_valid", valid_a, 0);
            else begin
               check_eq("a_gx", gx_a, qa[0].gx);
               check_eq("a_gy", gy_a, qa[0].gy);
               check_eq("a_mag", mag_a, qa[0].mag);
               check_eq("a_edge", edge_a, qa[0].edg);
               check_eq("a_sof", sof_a, qa[0].sof);
               check_eq("a_eol", eol_a, qa[0].eol);
               if (out_ready) void'(qa.pop_front());
               else check_eq("a_ready_stall", ready_a, 0);
            end
         end
         if (valid_b) begin
            if (qb.size() == 0) check_eq("b_spurious_valid", valid_b, 0);
            else begin
               check_eq("b_gx", gx_b, qb[0].gx);
               check_eq("b_gy", gy_b, qb[0].gy);
               check_eq("b_mag", mag_b, qb[0].mag);
               check_eq("b_edge", edge_b, qb[0].edg);
               check_eq("b_sof", sof_b, qb[0].sof);
               check_eq("b_eol", eol_b, qb[0].eol);
               if (out_ready) void'(qb.pop_front());
               else check_eq("b_ready_stall", ready_b, 0);
            end
         end
         if (in_valid && ready_a) qa.push_back(model(KA, MWA, pa, mode, int'(thr_a), in_sof, in_eol));
         if (in_valid && ready_b) qb.push_back(model(KB, MWB, pb, mode, int'(thr_b), in_sof, in_eol));
      end
   end

   // Downstream ready: 0 always ready, 1 toggling, otherwise random.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int pat, input bit s, input bit e);
      bit acc;
      int guard;
      acc   = 1'b0;
      guard = 0;
      fill(pat);
      in_valid = 1'b1;
      in_sof   = s;
      in_eol   = e;
      while (!acc && guard < 100) begin
         @(negedge clk);
         acc = ready_a;
         step();
         guard++;
      end
      if (!acc) check_eq("send_timeout", acc, 1);
      in_valid = 1'b0;
      in_sof   = 1'b0;
      in_eol   = 1'b0;
   endtask

   task automatic bubble();
      fill(3);
      in_valid = 1'b0;
      in_sof   = 1'($urandom_range(0, 1));
      in_eol   = 1'($urandom_range(0, 1));
      step();
      in_sof = 1'b0;
      in_eol = 1'b0;
   endtask

   task automatic stream(input int n, input int pat);
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 3) == 0) bubble();
         send((pat < 0) ? int'($urandom_range(0, 4)) : pat, (i == 0), (i == n - 1));
      end
   endtask

   task automatic drain();
      int g;
      g = 0;
      while ((qa.size() != 0 || qb.size() != 0) && g < 300) begin
         step();
         g++;
      end
      check_eq("drain_a", qa.size(), 0);
      check_eq("drain_b", qb.size(), 0);
   endtask

   // One transfer into an empty, always-ready pipe; returns in the cycle o_valid rises.
   task automatic single(input int pat, input bit md, input int ta, input int tb);
      int lat;
      mode  = md;
      thr_a = ta[MWA-1:0];
      thr_b = tb[MWB-1:0];
      fill(pat);
      in_valid = 1'b1;
      in_sof   = 1'b1;
      in_eol   = 1'b1;
      step();
      in_valid = 1'b0;
      in_sof   = 1'b0;
      in_eol   = 1'b0;
      lat = 1;
      while (!valid_a && lat < 20) begin
         step();
         lat++;
      end
      check_eq("latency", lat, 4);
   endtask

   initial begin
      aresetn  = 1'b0;
      in_valid = 1'b0;
      in_sof   = 1'b0;
      in_eol   = 1'b0;
      mode     = 1'b0;
      thr_a    = 16'd500;
      thr_b    = 8'd20;
      fill(0);
      repeat (3) step();
      check_eq("rst_valid", valid_a, 0);
      check_eq("rst_gx", gx_a, 0);
      check_eq("rst_mag", mag_a, 0);
      check_eq("rst_edge", edge_a, 0);
      check_eq("rst_ready", ready_a, 1);
      aresetn = 1'b1;
      step();

      single(0, 1'b0, 500, 20);
      check_eq("ramp_gx", gx_a, -90);
      check_eq("ramp_gy", gy_a, -450);
      check_eq("ramp_l1", mag_a, 540);
      check_eq("ramp_edge", edge_a, 1);
      check_eq("ramp_sof", sof_a, 1);
      check_eq("k3_gx", gx_b, -8);
      check_eq("k3_gy", gy_b, -24);
      check_eq("k3_l1", mag_b, 32);
      step();
      check_eq("one_cycle_valid", valid_a, 0);

      single(0, 1'b1, 500, 20);
      check_eq("ramp_approx", mag_a, 495);
      check_eq("ramp_approx_edge", edge_a, 0);
      check_eq("k3_approx", mag_b, 28);
      step();

      single(1, 1'b0, 500, 20);
      check_eq("flat_gx", gx_a, 0);
      check_eq("flat_gy", gy_a, 0);
      check_eq("flat_mag", mag_a, 0);
      step();

      single(2, 1'b0, 500, 20);
      check_eq("step_gx", gx_a, 6885);
      check_eq("step_mag", mag_a, 6885);
      check_eq("k3_sat_gx", gx_b, 1020);
      check_eq("k3_sat_mag", mag_b, 255);
      step();

      rdy_mode = 1;
      mode     = 1'b0;
      stream(10, 3);
      drain();

      for (int ph = 0; ph < 8; ph++) begin
         mode     = 1'($urandom_range(0, 1));
         thr_a    = 16'($urandom_range(0, 14000));
         thr_b    = 8'($urandom_range(0, 255));
         rdy_mode = int'($urandom_range(0, 2));
         step();
         stream(30, -1);
         drain();
      end

      rdy_mode = 2;
      stream(12, -1);
      @(posedge clk);
      #3;
      aresetn = 1'b0;
      #1;
      check_eq("midrst_valid_a", valid_a, 0);
      check_eq("midrst_valid_b", valid_b, 0);
      check_eq("midrst_gx", gx_a, 0);
      check_eq("midrst_mag", mag_a, 0);
      check_eq("midrst_edge", edge_a, 0);
      check_eq("midrst_sof", sof_a, 0);
      qa.delete();
      qb.delete();
      in_valid = 1'b0;
      repeat (2) step();
      aresetn  = 1'b1;
      rdy_mode = 0;
      step();
      stream(10, -1);
      drain();
      repeat (6) step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
